// File: rtl/melody_player.sv
// melody_player: plays one of four fixed melodies as a square wave on beep.
// Build with MELODY_PREEMPT_EN defined to let start abort a running melody.
module melody_player #(
    parameter int CLK_HZ    = 100000000,
    parameter int NOTE_MS   = 125,
    parameter int MAX_NOTES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] sel,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic       done
);
    localparam int TICK_CYCLES = CLK_HZ / 1000 * NOTE_MS;

    function automatic int hp_calc(input int f);
        int h;
        h = CLK_HZ / (2 * f);
        return (h < 1) ? 1 : h;
    endfunction

    localparam int HP_TAB [16] = '{
        1,
        hp_calc(262), hp_calc(294), hp_calc(330), hp_calc(349),
        hp_calc(392), hp_calc(440), hp_calc(494), hp_calc(523),
        hp_calc(587), hp_calc(659), hp_calc(698), hp_calc(784),
        hp_calc(880), hp_calc(988),
        1
    };

    localparam int HPW = $clog2(hp_calc(262) + 1);
    localparam int TW  = $clog2(TICK_CYCLES + 1);
    localparam int IW  = $clog2(MAX_NOTES + 1);

    localparam logic [3:0] N_REST = 4'd0;
    localparam logic [3:0] N_A4   = 4'd6;
    localparam logic [3:0] N_C5   = 4'd8;
    localparam logic [3:0] N_E5   = 4'd10;
    localparam logic [3:0] N_G5   = 4'd12;
    localparam logic [3:0] N_A5   = 4'd13;
    localparam logic [3:0] N_END  = 4'd15;
    localparam logic [7:0] END_E  = {N_END, 4'd0};

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    function automatic logic [7:0] rom(input logic [1:0]    s,
                                       input logic [IW-1:0] i);
        logic [7:0] e;
        e = END_E;
        case (s)
            2'd0: case (i)
                IW'(0):  e = {N_A4, 4'd2};
                default: e = END_E;
            endcase
            2'd1: case (i)
                IW'(0):  e = {N_C5, 4'd1};
                IW'(1):  e = {N_E5, 4'd1};
                IW'(2):  e = {N_G5, 4'd2};
                default: e = END_E;
            endcase
            2'd2: case (i)
                IW'(0):  e = {N_C5, 4'd1};
                IW'(1):  e = {N_REST, 4'd1};
                IW'(2):  e = {N_C5, 4'd1};
                default: e = END_E;
            endcase
            default: case (i)
                IW'(0):  e = {N_A5, 4'd4};
                IW'(1):  e = {N_REST, 4'd1};
                IW'(2):  e = {N_A5, 4'd4};
                default: e = END_E;
            endcase
        endcase
        // Running off the table without an END marker still ends the melody
        if (int'(i) >= MAX_NOTES) e = END_E;
        return e;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       sel_q;
    logic [IW-1:0]    idx;
    logic [HPW-1:0]   tone_cnt;
    logic [TW-1:0]    tick_cnt;
    logic [3:0]       dur_cnt;
    logic             beep_q;
    logic             restart;
    logic             abort;

    logic [7:0]       entry;
    logic [3:0]       note;
    logic [3:0]       durm1;
    logic [HPW-1:0]   hp_m1;
    logic             is_end;
    logic             is_rest;
    logic             tick_last;
    logic             note_last;

    assign entry     = rom(sel_q, idx);
    assign note      = entry[7:4];
    assign durm1     = (entry[3:0] == 4'd0) ? 4'd0 : entry[3:0] - 4'd1;
    assign hp_m1     = HPW'(HP_TAB[note] - 1);
    assign is_end    = (note == N_END);
    assign is_rest   = (note == N_REST);
    assign tick_last = (tick_cnt == TW'(TICK_CYCLES - 1));
    assign note_last = tick_last && (dur_cnt == durm1);

`ifdef MELODY_PREEMPT_EN
    assign abort = start && (state_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    restart = 1'b1;
                end
            end
            LOAD:    state_d = is_end ? IDLE : PLAY;
            PLAY:    if (note_last) state_d = LOAD;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = LOAD;
            restart = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= 2'd0;
            idx      <= '0;
            tone_cnt <= '0;
            tick_cnt <= '0;
            dur_cnt  <= 4'd0;
            beep_q   <= 1'b0;
        end else begin
            if (restart) begin
                sel_q <= sel;
                idx   <= '0;
            end else if (state_q == PLAY && note_last) begin
                idx <= idx + IW'(1);
            end
            // Every note starts from a clean low phase with zeroed timers
            if (restart || state_q != PLAY || note_last) begin
                tone_cnt <= '0;
                tick_cnt <= '0;
                dur_cnt  <= 4'd0;
                beep_q   <= 1'b0;
            end else begin
                if (tick_last) begin
                    tick_cnt <= '0;
                    dur_cnt  <= dur_cnt + 4'd1;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
                if (is_rest) begin
                    tone_cnt <= '0;
                    beep_q   <= 1'b0;
                end else if (tone_cnt == hp_m1) begin
                    tone_cnt <= '0;
                    beep_q   <= ~beep_q;
                end else begin
                    tone_cnt <= tone_cnt + HPW'(1);
                end
            end
        end
    end

    assign beep = beep_q && !mute && !abort;
    assign busy = (state_q != IDLE);
    assign done = (state_q == LOAD) && is_end;
endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player at CLK_HZ=88000, NOTE_MS=10 (880-cycle tick).
// Expected beep follows a per-note model: level = (offset / HP) mod 2.
module tb_melody_player;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       mute = 1'b0;
    logic       beep;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_hp[$];
    int exp_len[$];

    melody_player #(
        .CLK_HZ(88000),
        .NOTE_MS(10),
        .MAX_NOTES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .sel(sel),
        .mute(mute),
        .beep(beep),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input int inj, input int m0, input int m1);
        start = (c == inj);
        if (c == inj) sel = 2'd3;
        mute = (c >= m0 && c < m1);
    endtask

    // Called in cycle 0; returns in cycle 1 (the LOAD cycle).
    task automatic begin_melody(input logic [1:0] s);
        sel = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Walks the melody in exp_hp/exp_len from its first LOAD cycle (c=1)
    // and counts cycles that deviate from the model.
    task automatic run_melody(input int inj, input int m0, input int m1,
                              output int bad, output int dn_at, output int ndone);
        int c;
        int e;
        bad = 0;
        dn_at = -1;
        ndone = 0;
        c = 1;
        for (int i = 0; i <= exp_hp.size(); i++) begin
            drive(c, inj, m0, m1);
            #1;
            if (beep !== 1'b0 || busy !== 1'b1) bad++;
            if (done === 1'b1) begin
                ndone++;
                dn_at = c;
            end
            if ((done === 1'b1) != (i == exp_hp.size())) bad++;
            tick();
            c++;
            if (i == exp_hp.size()) break;
            for (int k = 0; k < exp_len[i]; k++) begin
                drive(c, inj, m0, m1);
                #1;
                e = (exp_hp[i] == 0 || mute) ? 0 : (k / exp_hp[i]) % 2;
                if (beep !== e[0] || busy !== 1'b1) bad++;
                if (done === 1'b1) ndone++;
                tick();
                c++;
            end
        end
        start = 1'b0;
        mute = 1'b0;
        #1;
        if (busy !== 1'b0 || beep !== 1'b0) bad++;
        if (done === 1'b1) ndone++;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        start = 1'b1;
        sel = 2'd3;
        repeat (3) tick();
        start = 1'b0;
        #1;
        n_chk++;
        if (beep !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_beep: got %b want 0", beep);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        rst = 1'b0;
        bad = 0;
        repeat (2000) begin
            tick();
            if (beep !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: %0d active cycles, want 0", bad);
        end
    endtask

    task automatic test_sel0();
        int bad, dn_at, ndone;
        exp_hp = '{100};
        exp_len = '{1760};
        begin_melody(2'd0);
        run_melody(-1, -1, -1, bad, dn_at, ndone);
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sel0_wave: %0d bad cycles, want 0", bad);
        end
        n_chk++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL sel0_done_count: got %0d want 1", ndone);
        end
        n_chk++;
        if (dn_at != 1762) begin
            n_fail++;
            $display("FAIL sel0_done_cycle: got %0d want 1762", dn_at);
        end
    endtask

    task automatic test_sel1();
        int bad, dn_at, ndone;
        exp_hp = '{84, 66, 56};
        exp_len = '{880, 880, 1760};
        begin_melody(2'd1);
        run_melody(-1, -1, -1, bad, dn_at, ndone);
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sel1_wave: %0d bad cycles, want 0", bad);
        end
        n_chk++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL sel1_done_count: got %0d want 1", ndone);
        end
        n_chk++;
        if (dn_at != 3524) begin
            n_fail++;
            $display("FAIL sel1_done_cycle: got %0d want 3524", dn_at);
        end
    endtask

    task automatic test_mute();
        int bad, dn_at, ndone;
        exp_hp = '{84, 0, 84};
        exp_len = '{880, 880, 880};
        begin_melody(2'd2);
        run_melody(-1, 1200, 2000, bad, dn_at, ndone);
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mute_wave: %0d bad cycles, want 0", bad);
        end
        n_chk++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL mute_done_count: got %0d want 1", ndone);
        end
        n_chk++;
        if (dn_at != 2644) begin
            n_fail++;
            $display("FAIL mute_done_cycle: got %0d want 2644", dn_at);
        end
    endtask

    task automatic test_preempt();
        int bad, dn_at, ndone;
`ifdef MELODY_PREEMPT_EN
        begin_melody(2'd1);
        bad = 0;
        for (int c = 1; c < 500; c++) begin
            if (done === 1'b1 || busy !== 1'b1) bad++;
            tick();
        end
        start = 1'b1;
        sel = 2'd3;
        #1;
        n_chk++;
        if (beep !== 1'b0) begin
            n_fail++;
            $display("FAIL preempt_beep_kill: got %b want 0", beep);
        end
        tick();
        start = 1'b0;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL preempt_prefix: %0d bad cycles, want 0", bad);
        end
        exp_hp = '{50, 0, 50};
        exp_len = '{3520, 880, 3520};
        run_melody(-1, -1, -1, bad, dn_at, ndone);
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL preempt_wave: %0d bad cycles, want 0", bad);
        end
        n_chk++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL preempt_done_count: got %0d want 1", ndone);
        end
        n_chk++;
        if (dn_at != 7924) begin
            n_fail++;
            $display("FAIL preempt_done_cycle: got %0d want 7924", dn_at);
        end
`else
        exp_hp = '{84, 66, 56};
        exp_len = '{880, 880, 1760};
        begin_melody(2'd1);
        run_melody(500, -1, -1, bad, dn_at, ndone);
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ignore_start_wave: %0d bad cycles, want 0", bad);
        end
        n_chk++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL ignore_start_done_count: got %0d want 1", ndone);
        end
        n_chk++;
        if (dn_at != 3524) begin
            n_fail++;
            $display("FAIL ignore_start_done_cycle: got %0d want 3524", dn_at);
        end
`endif
    endtask

    task automatic test_rst_mid();
        int bad, dn_at, ndone;
        begin_melody(2'd3);
        repeat (299) tick();
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy_before: got %b want 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({beep, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %b want 000", {beep, busy, done});
        end
        exp_hp = '{50, 0, 50};
        exp_len = '{3520, 880, 3520};
        begin_melody(2'd3);
        run_melody(-1, -1, -1, bad, dn_at, ndone);
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_mid_replay_wave: %0d bad cycles, want 0", bad);
        end
        n_chk++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL rst_mid_done_count: got %0d want 1", ndone);
        end
        n_chk++;
        if (dn_at != 7924) begin
            n_fail++;
            $display("FAIL rst_mid_done_cycle: got %0d want 7924", dn_at);
        end
    endtask

    initial begin
        test_reset();
        test_sel0();
        test_sel1();
        test_mute();
        test_preempt();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/melody_player.md
Name: melody_player

Overview:
- Parametrised successor to the single-tone buzzer driver.
- Plays one of four fixed note sequences (melodies) on a single square-wave buzzer output, with a per-note pitch table and per-note duration.
- Sits between the ticket-machine control FSM and the board buzzer pin.
- Control pulses `start` with a melody select (coin accepted, selection confirm, ticket issued, error); the block reports `busy` and `done`.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- NOTE_MS, 125, length of one duration tick in ms. TICK_CYCLES = CLK_HZ/1000*NOTE_MS.
- MAX_NOTES, 16, ROM entries per melody; the index width is derived from it.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- sel  in  2  melody select; latched together with start.
- mute  in  1  forces beep low; sequencing continues.
- beep  out  1  buzzer square wave.
- busy  out  1  high in LOAD and PLAY.
- done  out  1  one-cycle pulse at melody end.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE; beep=0, busy=0, done=0; all counters and the index are 0.
- ROM entry = {note[3:0], dur[3:0]}.
  - note 0 = rest; note 15 = end marker.
  - note 1..14 = C4 262, D4 294, E4 330, F4 349, G4 392, A4 440, B4 494, C5 523, D5 587, E5 659, F5 698, G5 784, A5 880, B5 988 Hz.
  - dur is in ticks; dur=0 is treated as 1.
- Half-period HP = CLK_HZ/(2*f), integer division at elaboration, clamped to a minimum of 1.
- Melody contents, fixed:
  - sel=0: {A4,2},{END}
  - sel=1: {C5,1},{E5,1},{G5,2},{END}
  - sel=2: {C5,1},{REST,1},{C5,1},{END}
  - sel=3: {A5,4},{REST,1},{A5,4},{END}
  - Unused entries hold END.
- IDLE:
  - On start=1, latch sel, set index=0, go to LOAD next cycle.
- LOAD (exactly 1 cycle):
  - beep=0, tone counter=0, tick and duration counters=0.
  - If the entry at index is END: done=1 this cycle, then IDLE.
  - Otherwise go to PLAY.
  - index reaching MAX_NOTES without an END is treated as END.
- PLAY:
  - The tone counter increments each cycle. When it equals HP-1, beep toggles and the counter clears. The first toggle therefore occurs HP cycles after entering PLAY.
  - Rest: beep held 0, tone counter held 0.
  - The note lasts exactly max(dur,1)*TICK_CYCLES cycles in PLAY. Then index increments and the state goes to LOAD.
- mute=1: the beep output is 0 combinationally gated from the internal toggle flop. Timing is unaffected; the flop keeps toggling.
- start while busy: ignored, unless PREEMPT_EN (see Optional Feature).
- Latency: start at cycle N → LOAD at N+1 → PLAY at N+2.
- rst mid-melody: next cycle is IDLE with all outputs 0. No done pulse.
- Counters are sized for TICK_CYCLES*16 and the largest HP without overflow.

Optional Feature:
- Macro: MELODY_PREEMPT_EN.
- Defined: start=1 in LOAD or PLAY aborts the current melody.
  - Re-latches sel, sets index=0, goes to LOAD next cycle.
  - beep is forced to 0 on that cycle. No done pulse for the aborted melody.
  - start in the cycle where done=1 also restarts, and done still pulses.
- Undefined: start is ignored outside IDLE.

Test Plan (CLK_HZ=88000, NOTE_MS=10 → TICK_CYCLES=880; HP: A4=100, C5=84, E5=66, G5=56, A5=50):
- Reset check: rst held 3 cycles → beep=0, busy=0, done=0. With start=0, outputs stay 0 for 2000 cycles.
- sel=0: start at cycle 0.
  - busy=1 from cycle 1.
  - PLAY cycles 2..1761 with 17 beep toggles, each 100 cycles apart, the first at cycle 102.
  - LOAD at cycle 1762 with done=1; busy=0 at cycle 1763.
- sel=1:
  - Measured half-periods are 84 for 880 cycles, then 66 for 880 cycles, then 56 for 1760 cycles.
  - beep=0 in each single LOAD cycle between notes.
  - Exactly one done pulse.
- sel=2 with mute pulsed high mid-second-note:
  - Rest window of 880 cycles has beep=0.
  - beep=0 while mute=1.
  - done occurs at the same cycle as the unmuted run.
- start with sel=3 asserted during PLAY of sel=1:
  - Without the macro: ignored, and the sel=1 timing is unchanged.
  - With MELODY_PREEMPT_EN: the next cycle is LOAD, then HP=50 tone; no done pulse for sel=1.
- rst asserted during PLAY of sel=3 → next cycle beep=0, busy=0, done=0. A subsequent start plays sel=3 from its first note.
